// File: rtl/video_scanout.sv
// Raster scanout: free-running sync timing, FIFO-fed active pixels, DMA start and underflow count.
// Optional colour-bar generator enabled by defining VIDEO_SCANOUT_TEST_PATTERN_EN (adds input test_en).
module video_scanout #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int PREFILL  = 1024,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_w,
    input  logic        rst_n,
    input  logic        enable,
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    output logic        dma_start,
    output logic        fifo_rdreq,
    input  logic [23:0] fifo_q,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_usedw,
    output logic [23:0] vid_rgb,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic        frame_start,
    output logic        running,
    output logic [15:0] underflow_cnt
);

    // state   | meaning
    // IDLE    | scanout off, DMA held idle, raster still timing
    // PREFILL | DMA running, black output, waiting for fill level at frame end
    // RUN     | one FIFO pop per active pixel, underflows counted

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0]   PF_LVL = 12'(PREFILL);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [15:0]     uf_q, uf_d;
    logic            uf_clr;

    logic            act1_q, hs1_q, vs1_q, pop1_q, first1_q;
    logic            de2_q, hs2_q, vs2_q, fs2_q;
    logic [23:0]     rgb2_q, rgb_d;

    logic            act_c, hs_c, vs_c, frame_end_c, tp_c;

`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
    logic            tp1_q;
    logic [23:0]     bar1_q, bar_c;

    always_comb begin
        case (3'(h_q >> 7))
            3'd0:    bar_c = 24'hFFFFFF;
            3'd1:    bar_c = 24'hFFFF00;
            3'd2:    bar_c = 24'h00FFFF;
            3'd3:    bar_c = 24'h00FF00;
            3'd4:    bar_c = 24'hFF00FF;
            3'd5:    bar_c = 24'hFF0000;
            3'd6:    bar_c = 24'h0000FF;
            default: bar_c = 24'h000000;
        endcase
    end

    assign tp_c = test_en;
`else
    assign tp_c = 1'b0;
`endif

    assign act_c       = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_c        = (h_q >= H_SS) && (h_q < H_SE);
    assign vs_c        = (v_q >= V_SS) && (v_q < V_SE);
    assign frame_end_c = (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        dma_start  = 1'b0;
        fifo_rdreq = 1'b0;
        uf_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_PREFILL;
                    uf_clr  = 1'b1;
                end
            end
            S_PREFILL: begin
                dma_start = 1'b1;
                if (frame_end_c && (fifo_usedw >= PF_LVL))
                    state_d = S_RUN;
            end
            S_RUN: begin
                dma_start  = 1'b1;
                fifo_rdreq = act_c && !fifo_empty && !tp_c;
            end
            default: state_d = S_IDLE;
        endcase
        // enable low wins over every other transition and cuts requests this clock
        if (!enable) begin
            state_d    = S_IDLE;
            dma_start  = 1'b0;
            fifo_rdreq = 1'b0;
        end
    end

    always_comb begin
        uf_d = uf_q;
        if (uf_clr)
            uf_d = '0;
        else if (enable && (state_q == S_RUN) && act_c && fifo_empty && !tp_c
                 && (uf_q != 16'hFFFF))
            uf_d = uf_q + 16'd1;
    end

    always_comb begin
        rgb_d = pop1_q ? fifo_q : 24'h000000;
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
        if (tp1_q)
            rgb_d = act1_q ? bar1_q : 24'h000000;
`endif
    end

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            uf_q     <= '0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            pop1_q   <= 1'b0;
            first1_q <= 1'b0;
            de2_q    <= 1'b0;
            hs2_q    <= ~SYNC_POL;
            vs2_q    <= ~SYNC_POL;
            fs2_q    <= 1'b0;
            rgb2_q   <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            uf_q     <= uf_d;
            act1_q   <= act_c;
            hs1_q    <= hs_c;
            vs1_q    <= vs_c;
            pop1_q   <= fifo_rdreq;
            first1_q <= (h_q == '0) && (v_q == '0) && (state_q == S_RUN);
            de2_q    <= act1_q;
            hs2_q    <= hs1_q ? SYNC_POL : ~SYNC_POL;
            vs2_q    <= vs1_q ? SYNC_POL : ~SYNC_POL;
            fs2_q    <= first1_q;
            rgb2_q   <= rgb_d;
        end
    end

`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            tp1_q  <= 1'b0;
            bar1_q <= '0;
        end else begin
            tp1_q  <= tp_c;
            bar1_q <= bar_c;
        end
    end
`endif

    assign vid_rgb       = rgb2_q;
    assign vid_hs        = hs2_q;
    assign vid_vs        = vs2_q;
    assign vid_de        = de2_q;
    assign frame_start   = fs2_q;
    assign running       = (state_q == S_RUN);
    assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout on a reduced raster: frame-position model, bench-owned FIFO data, literal pins.
module tb_video_scanout;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;
    localparam int PF = 20;

    logic        clk_w = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dma_start, fifo_rdreq;
    logic [23:0] fifo_q = '0;
    logic        fifo_empty = 1'b1;
    logic [11:0] fifo_usedw = '0;
    logic [23:0] vid_rgb;
    logic        vid_hs, vid_vs, vid_de, frame_start, running;
    logic [15:0] underflow_cnt;

    video_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PREFILL(PF), .SYNC_POL(1'b0)
    ) dut (
        .clk_w(clk_w), .rst_n(rst_n), .enable(enable),
        .dma_start(dma_start), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
        .vid_rgb(vid_rgb), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .frame_start(frame_start), .running(running), .underflow_cnt(underflow_cnt)
    );

    always #5 clk_w = ~clk_w;

    typedef struct {
        logic        de, hs, vs, fs;
        logic [23:0] rgb;
    } pix_t;

    pix_t        d1, d2, rst_pix;
    int          n, ms;          // ms: 0 idle, 1 prefill, 2 run
    int          uf, wctr;
    bit          rnd_data;
    logic        last_rd;
    logic [23:0] pend;
    int          total = 0, bad = 0;
    int          t_de, t_hs, t_vs, t_rd, t_black, fs_cnt;
    logic [23:0] fs_rgb [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", nm, got, want, n);
        end
    endtask

    function automatic bit is_act(input int c);
        return ((c % HT) < HA) && (((c / HT) % VT) < VA);
    endfunction

    task automatic model_reset();
        n = 0; ms = 0; uf = 0; last_rd = 1'b0;
        d1 = rst_pix; d2 = rst_pix;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_de"}, 32'(vid_de), 0);
        chk({tag, "_hs"}, 32'(vid_hs), 1);
        chk({tag, "_vs"}, 32'(vid_vs), 1);
        chk({tag, "_rgb"}, 32'(vid_rgb), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_dma"}, 32'(dma_start), 0);
        chk({tag, "_rdreq"}, 32'(fifo_rdreq), 0);
        chk({tag, "_uf"}, 32'(underflow_cnt), 0);
    endtask

    // One raster clock: check pipelined outputs, drive inputs, check request outputs, advance model.
    task automatic step(input logic en, input logic emp, input logic [11:0] uw);
        int h, v;
        bit act, exp_rd;
        pix_t e;
        logic [23:0] val;
        @(negedge clk_w);
        chk("vid_de", 32'(vid_de), 32'(d2.de));
        chk("vid_hs", 32'(vid_hs), 32'(d2.hs));
        chk("vid_vs", 32'(vid_vs), 32'(d2.vs));
        chk("vid_rgb", 32'(vid_rgb), 32'(d2.rgb));
        chk("frame_start", 32'(frame_start), 32'(d2.fs));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(uf));
        t_de += int'(vid_de);
        t_hs += int'(!vid_hs);
        t_vs += int'(!vid_vs);
        t_black += int'(vid_de && (vid_rgb == 24'h0));
        if (frame_start) begin
            if (fs_cnt < 8) fs_rgb[fs_cnt] = vid_rgb;
            fs_cnt++;
        end
        fifo_q     = last_rd ? pend : 24'($urandom());
        enable     = en;
        fifo_empty = emp;
        fifo_usedw = uw;
        #1;
        h = n % HT;
        v = (n / HT) % VT;
        act = (h < HA) && (v < VA);
        exp_rd = en && (ms == 2) && act && !emp;
        chk("fifo_rdreq", 32'(fifo_rdreq), 32'(exp_rd));
        chk("dma_start", 32'(dma_start), 32'(en && (ms != 0)));
        chk("running", 32'(running), 32'(ms == 2));
        t_rd += int'(fifo_rdreq);
        val = 24'h0;
        if (exp_rd) begin
            val = rnd_data ? 24'($urandom()) : 24'(wctr);
            wctr++;
            pend = val;
        end
        e.de  = act;
        e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        e.rgb = val;
        e.fs  = (h == 0) && (v == 0) && (ms == 2);
        if (en && (ms == 2) && act && emp && (uf < 65535)) uf++;
        if (!en) ms = 0;
        else if (ms == 0) begin ms = 1; uf = 0; end
        else if ((ms == 1) && (h == HT - 1) && (v == VT - 1) && (int'(uw) >= PF)) ms = 2;
        d2 = d1;
        d1 = e;
        last_rd = exp_rd;
        n++;
    endtask

    task automatic clear_tally();
        t_de = 0; t_hs = 0; t_vs = 0; t_rd = 0; t_black = 0;
    endtask

    initial begin
        int k, guard;
        rst_pix.de = 1'b0; rst_pix.hs = 1'b1; rst_pix.vs = 1'b1;
        rst_pix.fs = 1'b0; rst_pix.rgb = '0;
        rnd_data = 1'b0; wctr = 0; fs_cnt = 0; pend = '0;
        clear_tally();
        model_reset();

        #23;
        chk_reset("por");
        @(posedge clk_w); #1 rst_n = 1'b1;

        // raster timing with scanout off
        step(0, 1, 0); step(0, 1, 0);
        clear_tally();
        for (int i = 0; i < VT * HT; i++) step(0, 1, 0);
        chk("frame_de_clks", 32'(t_de), 32'(HA * VA));
        chk("frame_hs_clks", 32'(t_hs), 32'(HSW * VT));
        chk("frame_vs_clks", 32'(t_vs), 32'(VSW * HT));
        chk("frame_rd_clks", 32'(t_rd), 0);

        // prefill below threshold, then raise it mid-frame
        for (int i = 0; i < 360; i++) step(1, 0, 12'd10);
        chk("prefill_dma", 32'(dma_start), 1);
        chk("prefill_running", 32'(running), 0);
        guard = 0;
        while (ms != 2 && guard < 600) begin step(1, 0, 12'd30); guard++; end
        chk("reach_run", 32'(ms == 2), 1);
        repeat (3) step(1, 0, 12'd30);
        chk("first_fs_cnt", 32'(fs_cnt), 1);
        chk("first_pixel", 32'(fs_rgb[0]), 0);

        // incrementing data across two frame wraps
        for (int i = 0; i < 2 * VT * HT; i++) step(1, 0, 12'd30);
        chk("fs_cnt_3", 32'(fs_cnt), 3);
        chk("frame2_first", 32'(fs_rgb[1]), 32'(HA * VA));
        chk("frame3_first", 32'(fs_rgb[2]), 32'(2 * HA * VA));

        // ten underflowed active clocks
        clear_tally();
        k = 0;
        while (k < 10) begin
            if (is_act(n)) begin step(1, 1, 12'd30); k++; end
            else step(1, 0, 12'd30);
        end
        repeat (3) step(1, 0, 12'd30);
        chk("uf_count_10", 32'(underflow_cnt), 10);
        chk("uf_black_10", 32'(t_black), 10);

        // drop enable mid active line
        guard = 0;
        while (!((n % HT) == 5 && ((n / HT) % VT) < VA) && guard < 400) begin
            step(1, 0, 12'd30); guard++;
        end
        step(0, 0, 12'd30);
        chk("drop_rdreq", 32'(fifo_rdreq), 0);
        chk("drop_dma", 32'(dma_start), 0);
        repeat (20) step(0, 0, 12'd30);
        chk("uf_held", 32'(underflow_cnt), 10);
        step(1, 0, 12'd30);
        step(1, 0, 12'd30);
        chk("uf_cleared", 32'(underflow_cnt), 0);

        // randomized traffic
        rnd_data = 1'b1;
        for (int i = 0; i < 1500; i++)
            step(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 3) == 0),
                 12'($urandom_range(0, 40)));

        // asynchronous reset while running
        guard = 0;
        while (ms != 2 && guard < 600) begin step(1, 0, 12'd30); guard++; end
        chk("reach_run2", 32'(ms == 2), 1);
        repeat (37) step(1, logic'($urandom_range(0, 3) == 0), 12'd30);
        @(negedge clk_w);
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        repeat (3) @(posedge clk_w);
        #1 chk_reset("held");
        model_reset();
        @(posedge clk_w); #1 rst_n = 1'b1;
        for (int i = 0; i < 600; i++)
            step(1, logic'($urandom_range(0, 4) == 0), 12'($urandom_range(15, 40)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Display-side consumer of the 24-bit pixel FIFO that the SDRAM DMA reader fills.
- Generates 1024x768 raster timing and pops one FIFO word per active pixel.
- Drives RGB/HS/VS/DE to the video transmitter and raises the DMA start level once the FIFO holds enough pixels.
- Counts underflows so that software can tune the DMA burst and cooldown settings.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- PREFILL, 1024, FIFO usedw threshold required before scanout starts
- SYNC_POL, 0, active level of vid_hs/vid_vs (0 = active-low)

Ports:
- clk_w  in  1  pixel clock; also the FIFO read clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = scanout requested
- dma_start  out  1  level start to the DMA reader
- fifo_rdreq  out  1  FIFO read request; normal (non-show-ahead) FIFO, q valid 1 clk after rdreq
- fifo_q  in  24  pixel data: [23:16] R, [15:8] G, [7:0] B
- fifo_empty  in  1  FIFO empty flag
- fifo_usedw  in  12  FIFO fill level
- vid_rgb  out  24  output pixel
- vid_hs  out  1  horizontal sync
- vid_vs  out  1  vertical sync
- vid_de  out  1  data enable
- frame_start  out  1  1-clk pulse aligned with the first active pixel of each frame
- running  out  1  1 while in state RUN
- underflow_cnt  out  16  saturating count of underflowed pixels

Behaviour:
- Reset (rst_n=0, asynchronous):
  - h_cnt=0, v_cnt=0, state=IDLE.
  - All outputs 0, except vid_hs/vid_vs, which reset to the inactive level (!SYNC_POL).
- Timing counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=1344; V_TOTAL=806.
  - h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on each h wrap and wraps at V_TOTAL-1.
  - Counters free-run in every state, so sync is always present.
- Raw (stage-0) timing signals:
  - act_c=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs_c is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_c is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Pipeline:
  - Stage 1 registers act/hs/vs plus a "popped" flag.
  - Stage 2 registers the outputs. Pin latency is 2 clocks from the counters.
  - vid_de is stage-1 act. vid_rgb = fifo_q if popped, else 24'h000000. vid_rgb = 0 whenever vid_de=0.
- States:
  - IDLE: dma_start=0, fifo_rdreq=0. Goes to PREFILL when enable=1.
  - PREFILL: dma_start=1, no reads, output black with sync.
    - Goes to RUN on the last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) if fifo_usedw>=PREFILL.
    - If the fill level is not reached at that clock, waits for the next frame end.
  - RUN: dma_start=1, running=1, fifo_rdreq=act_c && !fifo_empty.
  - Any state goes to IDLE when enable=0, taking effect the same clock:
    - fifo_rdreq drops immediately and dma_start=0.
    - Already-popped pixels drain through the pipeline; no partial-pixel hazard.
- Underflow:
  - In RUN, act_c=1 with fifo_empty=1 means the pixel is not popped and is output black.
  - underflow_cnt increments by 1 per such clock and saturates at 16'hFFFF.
  - underflow_cnt clears only on reset or on the IDLE->PREFILL transition.
  - Scanout stays in RUN; the raster never stalls.
- frame_start: stage-2 pulse when the output pixel is (h=0, v=0) and state is RUN.
- Simultaneous events: enable falling on the PREFILL->RUN clock goes to IDLE, because enable has priority.
- Width: fifo_usedw is compared unsigned at 12 bits; PREFILL must be <=4095.

Optional Feature:
- Macro: VIDEO_SCANOUT_TEST_PATTERN_EN.
- When defined, adds input test_en (1 bit). test_en=1 forces 8 vertical colour bars, each 128 pixels wide, in the order:
  - white, yellow, cyan, green, magenta, red, blue, black.
- With test_en=1:
  - FIFO reads are suppressed and underflow counting is frozen.
  - Timing, DE and the dma_start behaviour are unchanged.
- When the macro is undefined, the port does not exist and the output is always FIFO data or black.

Test Plan:
- Reset, then hold enable=0 for 1 frame: dma_start=0, fifo_rdreq never 1, vid_de high exactly 1024 clks per active line, HS low 136 clks every 1344 clks, VS low 6 lines every 806 lines.
- enable=1 with fifo_usedw=1000: stays in PREFILL with dma_start=1. Raise fifo_usedw to 2000 mid-frame: RUN begins at the next frame boundary, frame_start pulses, and the first vid_rgb equals the first popped fifo_q.
- In RUN, feed an incrementing pattern 0,1,2...: vid_rgb[line0] = 0..1023, with no gap or duplicate across the line and frame wrap.
- Force fifo_empty=1 for 10 active clocks: 10 black pixels, underflow_cnt=10, fifo_rdreq low during those clocks, sync unaffected.
- Drop enable mid-line in RUN: fifo_rdreq goes to 0 the same clock, dma_start goes to 0, counters keep running. Re-enable: underflow_cnt clears.
- Assert rst_n=0 asynchronously mid-frame: all outputs go to their reset values without waiting for a clock edge.
